lzrw1_decompressor_core: RTL and testbench

Parametrised LZRW1 item decoder. Successor to decompressor_top with configurable history depth and offset/length split, an output ready/valid handshake with backpressure, and a sticky bad-offset error.
Consumes one 16-bit item per handshake, tagged by its control bit, and emits decompressed bytes one per cycle into a downstream byte sink. Sits between the compressed-stream unpacker and the output buffer.

---
 rtl/lzrw1_decompressor_core_if.sv | 27 ++
 rtl/lzrw1_decompressor_core.sv | 130 +++++++++++++
 tb/tb_lzrw1_decompressor_core.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lzrw1_decompressor_core_if.sv
// Item-in / byte-out handshake bundle for the LZRW1 item decoder.
// The master drives items and out_ready; the slave is the decoder.
interface lzrw1_decompressor_core_if;
    logic [15:0] data_in;
    logic        control_word_in;
    logic        data_in_valid;
    logic        frame_start;
    logic        decompressor_busy;
    logic [7:0]  decompressed_byte;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        error;
    logic [31:0] bytes_out;

    modport master (
        output data_in, control_word_in, data_in_valid, frame_start, out_ready,
        input  decompressor_busy, decompressed_byte, out_valid, out_last,
        input  error, bytes_out
    );

    modport slave (
        input  data_in, control_word_in, data_in_valid, frame_start, out_ready,
        output decompressor_busy, decompressed_byte, out_valid, out_last,
        output error, bytes_out
    );
endinterface

// File: rtl/lzrw1_decompressor_core.sv
// Parametrised LZRW1 item decoder: literal/copy items in, one byte per
// cycle out through a ready/valid register, sticky bad-offset error.
module lzrw1_decompressor_core #(
    parameter int HISTORY_SIZE = 4096,
    parameter int OFFSET_WIDTH = 12,
    parameter int MIN_MATCH    = 3
) (
    input logic clock,
    input logic reset,
    lzrw1_decompressor_core_if.slave bus
);
    localparam int AW = $clog2(HISTORY_SIZE);
    localparam int CW = 17;
    localparam logic [AW:0]   AVAIL_MAX = (AW+1)'(HISTORY_SIZE);
    localparam logic [AW:0]   ONE_A     = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_P     = AW'(1);
    localparam logic [31:0]   HIST      = 32'(HISTORY_SIZE);

    typedef enum logic [1:0] {IDLE, EMIT, ERR} state_t;

    state_t state, state_next;

    logic [7:0]    hist [HISTORY_SIZE];
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   avail;
    logic [CW-1:0] remain;
    logic          is_copy;
    logic [7:0]    lit_byte;
    logic [AW-1:0] off_q;
    logic [7:0]    byte_q;
    logic          valid_q;
    logic          last_q;
    logic          err_q;
    logic [31:0]   count_q;

    logic                    accept;
    logic                    fs;
    logic [OFFSET_WIDTH-1:0] in_off;
    logic [CW-1:0]           in_len;
    logic [AW:0]             avail_eff;
    logic                    bad;
    logic                    gen;
    logic                    last_gen;
    logic [AW-1:0]           rd_addr;
    logic [7:0]              gen_byte;

    assign accept    = (state == IDLE) && bus.data_in_valid;
    assign fs        = (state == IDLE) && bus.frame_start;
    assign in_off    = bus.data_in[OFFSET_WIDTH-1:0];
    assign in_len    = CW'(bus.data_in[15:OFFSET_WIDTH]) + CW'(MIN_MATCH);
    // frame_start clears occupancy before the same-cycle item is checked
    assign avail_eff = fs ? '0 : avail;
    assign bad       = (in_off == '0)
                    || (32'(in_off) > 32'(avail_eff))
                    || (32'(in_off) > HIST);
    assign gen       = (state == EMIT) && (!valid_q || bus.out_ready);
    assign last_gen  = (remain == CW'(1));
    assign rd_addr   = wr_ptr - off_q;
    assign gen_byte  = is_copy ? hist[rd_addr] : lit_byte;

    assign bus.decompressor_busy = (state != IDLE);
    assign bus.decompressed_byte = byte_q;
    assign bus.out_valid         = valid_q;
    assign bus.out_last          = last_q;
    assign bus.error             = err_q;
    assign bus.bytes_out         = count_q;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept)
                state_next = (bus.control_word_in && bad) ? ERR : EMIT;
            EMIT: if (gen && last_gen)
                state_next = IDLE;
            ERR:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            avail    <= '0;
            remain   <= '0;
            is_copy  <= 1'b0;
            lit_byte <= '0;
            off_q    <= '0;
            byte_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state <= state_next;
            if (valid_q && bus.out_ready)
                count_q <= count_q + 32'd1;
            if (fs) begin
                avail <= '0;
                err_q <= 1'b0;
            end
            if (accept) begin
                is_copy  <= bus.control_word_in;
                lit_byte <= bus.data_in[7:0];
                off_q    <= AW'(in_off);
                remain   <= bus.control_word_in ? in_len : CW'(1);
                if (bus.control_word_in && bad)
                    err_q <= 1'b1;
            end
            if (gen) begin
                byte_q  <= gen_byte;
                valid_q <= 1'b1;
                last_q  <= last_gen;
                wr_ptr  <= wr_ptr + ONE_P;
                remain  <= remain - CW'(1);
                if (avail != AVAIL_MAX)
                    avail <= avail + ONE_A;
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    // History has no reset; only occupied entries are ever read
    always_ff @(posedge clock) begin
        if (gen)
            hist[wr_ptr] <= gen_byte;
    end
endmodule

// File: tb/tb_lzrw1_decompressor_core.sv
// Directed bench for lzrw1_decompressor_core: a 4096-entry and a 16-entry
// instance share stimulus; outputs of the selected one are checked.
module tb_lzrw1_decompressor_core;
    logic clock = 1'b0;
    logic rst = 1'b1;
    always #5 clock = ~clock;

    lzrw1_decompressor_core_if bus_b ();
    lzrw1_decompressor_core_if bus_s ();

    logic [15:0] d_in = '0;
    logic        cw = 1'b0;
    logic        vld = 1'b0;
    logic        fs = 1'b0;
    logic        rdy = 1'b1;

    assign bus_b.data_in = d_in;
    assign bus_b.control_word_in = cw;
    assign bus_b.data_in_valid = vld;
    assign bus_b.frame_start = fs;
    assign bus_b.out_ready = rdy;
    assign bus_s.data_in = d_in;
    assign bus_s.control_word_in = cw;
    assign bus_s.data_in_valid = vld;
    assign bus_s.frame_start = fs;
    assign bus_s.out_ready = rdy;

    lzrw1_decompressor_core u_big (
        .clock(clock),
        .reset(rst),
        .bus(bus_b)
    );

    lzrw1_decompressor_core #(.HISTORY_SIZE(16)) u_small (
        .clock(clock),
        .reset(rst),
        .bus(bus_s)
    );

    logic        sel = 1'b0;
    logic        obs_busy, obs_valid, obs_last, obs_err;
    logic [7:0]  obs_byte;
    logic [31:0] obs_cnt;
    assign obs_busy  = sel ? bus_s.decompressor_busy : bus_b.decompressor_busy;
    assign obs_valid = sel ? bus_s.out_valid : bus_b.out_valid;
    assign obs_last  = sel ? bus_s.out_last : bus_b.out_last;
    assign obs_err   = sel ? bus_s.error : bus_b.error;
    assign obs_byte  = sel ? bus_s.decompressed_byte : bus_b.decompressed_byte;
    assign obs_cnt   = sel ? bus_s.bytes_out : bus_b.bytes_out;

    int checks = 0;
    int errors = 0;

    // Ready driver: steady 1, or the 1,0,0,1 pattern for backpressure
    int         rdy_mode = 0;
    logic [1:0] bp_idx = '0;
    logic [3:0] pat = 4'b1001;
    always @(posedge clock) begin
        #1;
        if (rdy_mode == 1) begin
            rdy = pat[bp_idx];
            bp_idx = bp_idx + 2'd1;
        end else begin
            rdy = 1'b1;
        end
    end

    // Capture handshaked bytes; a stalled byte must hold until taken
    logic [8:0] cap[$];
    logic       hold_chk = 1'b0;
    logic [7:0] hold_byte = '0;
    always @(negedge clock) begin
        if (obs_valid && rdy)
            cap.push_back({obs_last, obs_byte});
        if (hold_chk) begin
            checks++;
            if (!obs_valid || obs_byte != hold_byte) begin
                errors++;
                $display("FAIL hold: valid=%0b byte=%02h required valid=1 byte=%02h",
                         obs_valid, obs_byte, hold_byte);
            end
        end
        hold_chk = obs_valid && !rdy && !rst;
        hold_byte = obs_byte;
    end

    task automatic chk(input string nm, input int idx,
                       input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h required %0h", nm, idx, act, exp);
        end
    endtask

    task automatic send(input logic c, input logic [15:0] d, input logic f);
        int n = 0;
        @(negedge clock);
        while (obs_busy && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) chk("send_timeout", 0, 1, 0);
        d_in = d;
        cw = c;
        fs = f;
        vld = 1'b1;
        @(negedge clock);
        vld = 1'b0;
        fs = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clock);
        while ((obs_busy || obs_valid) && n < 300) begin
            @(negedge clock);
            n++;
        end
        #1;
        if (n >= 300) chk("drain_timeout", 0, 1, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst = 1'b1;
        repeat (2) @(negedge clock);
        rst = 1'b0;
        #1;
    endtask

    task automatic chk_bytes(input string nm, input int n, input logic [63:0] exp);
        logic [7:0] e;
        chk({nm, "_count"}, 0, cap.size(), n);
        for (int k = 0; k < cap.size() && k < n; k++) begin
            e = exp[8*(k%8) +: 8];
            chk({nm, "_byte"}, k, cap[k][7:0], e);
            chk({nm, "_last"}, k, cap[k][8], (k == n - 1) ? 1 : 0);
        end
    endtask

    typedef struct {
        logic        c;
        logic [15:0] d;
        int          n;
        logic [63:0] exp;
    } vec_t;

    vec_t tv [6];

    initial begin
        int n;
        tv[0] = '{1'b0, 16'h0061, 1, 64'h61};
        tv[1] = '{1'b0, 16'h0062, 1, 64'h62};
        tv[2] = '{1'b0, 16'h0063, 1, 64'h63};
        tv[3] = '{1'b1, 16'h0002, 3, 64'h626362};
        tv[4] = '{1'b0, 16'h0F78, 1, 64'h78};
        tv[5] = '{1'b1, 16'hF001, 18, {8{8'h78}}};

        repeat (3) @(negedge clock);
        rst = 1'b0;
        #1;
        chk("rst_busy", 0, obs_busy, 0);
        chk("rst_valid", 0, obs_valid, 0);
        chk("rst_last", 0, obs_last, 0);
        chk("rst_byte", 0, obs_byte, 0);
        chk("rst_err", 0, obs_err, 0);
        chk("rst_cnt", 0, obs_cnt, 0);

        for (int i = 0; i < 6; i++) begin
            cap.delete();
            send(tv[i].c, tv[i].d, 1'b0);
            drain();
            chk_bytes($sformatf("vec%0d", i), tv[i].n, tv[i].exp);
            if (i == 2) chk("cnt_abc", i, obs_cnt, 3);
        end
        chk("cnt_table", 0, obs_cnt, 25);

        // Busy spans exactly the three generation cycles of a len-3 copy
        cap.delete();
        send(1'b1, 16'h0002, 1'b0);
        n = 0;
        while (obs_busy && n < 50) begin
            n++;
            @(negedge clock);
        end
        chk("busy_cycles", 0, n, 3);
        drain();
        chk_bytes("busy_copy", 3, 64'h787878);

        for (int i = 0; i < 5; i++) begin
            send(1'b0, 16'h0011 + 16'(i), 1'b0);
            drain();
        end
        cap.delete();
        rdy_mode = 1;
        send(1'b1, 16'h2005, 1'b0);
        drain();
        rdy_mode = 0;
        chk_bytes("bp", 5, 64'h1514131211);
        chk("cnt_bp", 0, obs_cnt, 38);

        // Bad offset right after frame_start, then sticky error and clear
        cap.delete();
        send(1'b1, 16'h0004, 1'b1);
        drain();
        chk("err_set", 0, obs_err, 1);
        chk("err_nobytes", 0, cap.size(), 0);
        send(1'b0, 16'h0041, 1'b0);
        drain();
        chk_bytes("after_err", 1, 64'h41);
        chk("err_sticky", 0, obs_err, 1);
        @(negedge clock);
        fs = 1'b1;
        @(negedge clock);
        fs = 1'b0;
        #1;
        chk("err_clear", 0, obs_err, 0);

        do_reset();
        sel = 1'b1;
        chk("s_rst_cnt", 0, obs_cnt, 0);
        for (int i = 0; i < 20; i++) begin
            send(1'b0, 16'(i), 1'b0);
            drain();
        end
        cap.delete();
        send(1'b1, 16'h0010, 1'b0);
        drain();
        chk_bytes("wrap", 3, 64'h060504);
        chk("wrap_err", 0, obs_err, 0);
        cap.delete();
        send(1'b1, 16'h0011, 1'b0);
        drain();
        chk("wrap17_err", 0, obs_err, 1);
        chk("wrap17_nobytes", 0, cap.size(), 0);

        do_reset();
        sel = 1'b0;
        send(1'b0, 16'h0030, 1'b0);
        drain();
        cap.delete();
        send(1'b1, 16'h7001, 1'b0);
        n = 0;
        while (cap.size() < 2 && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk("mid_two", 0, cap.size(), 2);
        rst = 1'b1;
        #1;
        chk("mid_valid", 0, obs_valid, 0);
        chk("mid_busy", 0, obs_busy, 0);
        @(negedge clock);
        rst = 1'b0;
        cap.delete();
        send(1'b0, 16'h0041, 1'b0);
        drain();
        chk_bytes("post_rst", 1, 64'h41);
        chk("post_rst_cnt", 0, obs_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
